ble_rx_dewhiten_crc: RTL and testbench
======================================

Name: ble_rx_dewhiten_crc

Overview:
- Receive-side PDU processor for the BLE TXRX datapath. Sits after the access-address correlator and before the RX byte FIFO.
- Takes the serial demodulated bit stream and de-whitens it with the channel-seeded 7-bit LFSR, using the same seed and polynomial as the TX whitener.
- Parses the 16-bit PDU header to obtain the payload length and emits PDU bytes.
- Checks the trailing 24-bit CRC and reports pass/fail.

Parameters:
- CH_IDX_W, 6, width of the channel index.
- MAX_LEN, 255, maximum accepted payload length in bytes.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse from the correlator: seed the LFSR and CRC, enter HDR
- abort  in  1  one-cycle pulse: drop the packet, return to IDLE
- ch_idx  in  CH_IDX_W  BLE channel index, sampled on start
- crc_init  in  24  CRC preset, sampled on start
- bit_in  in  1  received (whitened) bit
- bit_valid  in  1  qualifies bit_in; at most one bit per cycle
- rx_byte  out  8  de-whitened PDU byte, assembled LSB first
- rx_byte_valid  out  1  one-cycle strobe for rx_byte
- pdu_len  out  8  payload length from the header, valid once HDR completes
- busy  out  1  high in HDR/PAYLOAD/CRC
- done  out  1  one-cycle pulse at end of packet
- crc_ok  out  1  CRC result, held from done until the next start
- len_err  out  1  header length > MAX_LEN, held until the next start

Behaviour:
- Reset (rst_n low, asynchronous): FSM to IDLE. All outputs 0, LFSR 0, CRC register 0, counters 0.
- On start:
  - lfsr[0] = 1 and lfsr[i] = ch_idx[6-i] for i = 1..6.
  - crc = crc_init; bit counter = 0; crc_ok and len_err cleared.
  - FSM goes to HDR.
  - start in any state restarts the packet.
  - abort in the same cycle as start wins: FSM goes to IDLE.
- De-whitening, on each bit_valid in HDR/PAYLOAD/CRC:
  - d = bit_in ^ lfsr[6].
  - LFSR update: lfsr[6:5] <= lfsr[5:4]; lfsr[4] <= lfsr[6]^lfsr[3]; lfsr[3:1] <= lfsr[2:0]; lfsr[0] <= lfsr[6].
  - No LFSR advance when bit_valid is low.
- CRC-24, over de-whitened bits in HDR and PAYLOAD only:
  - fb = crc[23]^d.
  - crc <= {crc[22:0],1'b0} ^ (fb ? 24'h00065B : 0).
- Received CRC: the 24 de-whitened bits in the CRC state are shifted MSB-first into rx_crc.
- Byte assembly:
  - d enters an 8-bit shift register LSB first.
  - On every 8th bit in HDR/PAYLOAD, rx_byte_valid pulses in the cycle after that bit_valid.
  - CRC bytes are not emitted.
- FSM states:
  - IDLE: ignore bit_valid.
  - HDR: 16 bits. pdu_len = header bits [15:8], i.e. the second byte, latched with its rx_byte_valid.
    - If pdu_len > MAX_LEN: len_err = 1, done pulses with crc_ok = 0, go to IDLE.
    - If pdu_len == 0: go to CRC.
    - Otherwise: go to PAYLOAD.
  - PAYLOAD: 8*pdu_len bits, then CRC.
  - CRC: 24 bits. In the cycle after the 24th bit_valid, done = 1, crc_ok = (rx_crc == crc), go to IDLE.
- abort in any state:
  - Next cycle the FSM is in IDLE with no done and no rx_byte_valid.
  - A partially assembled byte is discarded; crc_ok is unchanged.
- Bits arriving in IDLE, or after done, are ignored.
- Gaps in bit_valid of any length are allowed and do not affect results.

Test Plan:
- ch_idx=0, crc_init=0x555555, start, then 16 zero bits.
  -> rx_byte 0x40 on the first strobe, i.e. de-whitened bits 0,0,0,0,0,0,1,0. This is the whitening sequence.
- Model-whitened packet on ch_idx=37: header 0x02,0x06, 6-byte payload, correct CRC, random bit_valid gaps.
  -> 8 rx_byte strobes match the plain bytes; pdu_len=6; done pulses once; crc_ok=1.
- Same packet with one CRC bit flipped -> done pulses, crc_ok=0; the data bytes are still correct.
- MAX_LEN=37, header length byte 0x40 -> len_err=1, done pulses with crc_ok=0 after bit 16, FSM returns to IDLE.
- Zero-length PDU (header 0x00,0x00 plus correct CRC) -> exactly 2 byte strobes, done after 40 bits, crc_ok=1.
- abort mid-payload, then start on the next cycle with a new packet on ch_idx=12 -> no done for the first packet; the second packet decodes with crc_ok=1.
- rst_n low mid-CRC -> all outputs 0 immediately; the next start decodes cleanly.

Source files
------------

// File: rtl/ble_rx_dewhiten_crc.sv
// BLE receive PDU processor: de-whitens the demodulated bit stream, frames header/payload
// bytes from the header length field and checks the trailing CRC-24.
module ble_rx_dewhiten_crc #(
  parameter int CH_IDX_W = 6,
  parameter int MAX_LEN  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [CH_IDX_W-1:0] ch_idx,
  input  logic [23:0]         crc_init,
  input  logic                bit_in,
  input  logic                bit_valid,
  output logic [7:0]          rx_byte,
  output logic                rx_byte_valid,
  output logic [7:0]          pdu_len,
  output logic                busy,
  output logic                done,
  output logic                crc_ok,
  output logic                len_err
);

  localparam logic [23:0] CRC_POLY  = 24'h00065B;
  localparam logic [8:0]  MAX_LEN_L = 9'(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_CRC} state_t;

  state_t      r_state, w_nxt;
  logic [6:0]  r_lfsr;
  logic [23:0] r_crc, r_rx_crc;
  logic [7:0]  r_sr, r_rx_byte, r_pdu_len;
  logic [10:0] r_cnt;
  logic        r_rx_byte_valid, r_done, r_crc_ok, r_len_err;

  logic        w_d, w_fb, w_step, w_last, w_len_bad;
  logic [7:0]  w_byte;
  logic [6:0]  w_seed;
  logic [10:0] w_pay_last;
  logic [23:0] w_rx_crc;

  // lfsr[0] is forced to 1; channel bit 5 lands in lfsr[1], channel bit 0 in lfsr[6]
  assign w_seed     = {ch_idx[0], ch_idx[1], ch_idx[2], ch_idx[3], ch_idx[4], ch_idx[5], 1'b1};
  assign w_d        = bit_in ^ r_lfsr[6];
  assign w_fb       = r_crc[23] ^ w_d;
  assign w_byte     = {w_d, r_sr[7:1]};
  assign w_rx_crc   = {r_rx_crc[22:0], w_d};
  assign w_len_bad  = {1'b0, w_byte} > MAX_LEN_L;
  assign w_pay_last = {r_pdu_len, 3'b000} - 11'd1;
  assign w_step     = bit_valid && (r_state != S_IDLE) && !start && !abort;

  always_comb begin
    w_last = 1'b0;
    case (r_state)
      S_HDR:     w_last = (r_cnt == 11'd15);
      S_PAYLOAD: w_last = (r_cnt == w_pay_last);
      S_CRC:     w_last = (r_cnt == 11'd23);
      default:   w_last = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    if (abort)
      w_nxt = S_IDLE;
    else if (start)
      w_nxt = S_HDR;
    else if (w_step && w_last) begin
      case (r_state)
        S_HDR:     w_nxt = w_len_bad ? S_IDLE : ((w_byte == 8'd0) ? S_CRC : S_PAYLOAD);
        S_PAYLOAD: w_nxt = S_CRC;
        S_CRC:     w_nxt = S_IDLE;
        default:   w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr          <= '0;
      r_crc           <= '0;
      r_rx_crc        <= '0;
      r_sr            <= '0;
      r_cnt           <= '0;
      r_rx_byte       <= '0;
      r_rx_byte_valid <= 1'b0;
      r_pdu_len       <= '0;
      r_done          <= 1'b0;
      r_crc_ok        <= 1'b0;
      r_len_err       <= 1'b0;
    end else begin
      r_rx_byte_valid <= 1'b0;
      r_done          <= 1'b0;
      if (abort) begin
        r_cnt <= '0;
        r_sr  <= '0;
      end else if (start) begin
        r_lfsr    <= w_seed;
        r_crc     <= crc_init;
        r_rx_crc  <= '0;
        r_sr      <= '0;
        r_cnt     <= '0;
        r_crc_ok  <= 1'b0;
        r_len_err <= 1'b0;
      end else if (w_step) begin
        r_lfsr <= {r_lfsr[5:4], r_lfsr[6] ^ r_lfsr[3], r_lfsr[2:0], r_lfsr[6]};
        r_sr   <= w_byte;
        r_cnt  <= w_last ? 11'd0 : r_cnt + 11'd1;
        if (r_state == S_CRC) begin
          r_rx_crc <= w_rx_crc;
          if (w_last) begin
            r_done   <= 1'b1;
            r_crc_ok <= (w_rx_crc == r_crc);
          end
        end else begin
          r_crc <= {r_crc[22:0], 1'b0} ^ (w_fb ? CRC_POLY : 24'd0);
          if (r_cnt[2:0] == 3'd7) begin
            r_rx_byte       <= w_byte;
            r_rx_byte_valid <= 1'b1;
          end
          // the length byte is the second header byte, so it completes on the last header bit
          if (r_state == S_HDR && w_last) begin
            r_pdu_len <= w_byte;
            if (w_len_bad) begin
              r_len_err <= 1'b1;
              r_done    <= 1'b1;
              r_crc_ok  <= 1'b0;
            end
          end
        end
      end
    end
  end

  assign rx_byte       = r_rx_byte;
  assign rx_byte_valid = r_rx_byte_valid;
  assign pdu_len       = r_pdu_len;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign crc_ok        = r_crc_ok;
  assign len_err       = r_len_err;

endmodule

// File: tb/tb_ble_rx_dewhiten_crc.sv
// Randomized bench for ble_rx_dewhiten_crc: packets are built and whitened by a polynomial
// model, expected bytes/done results are queued and a monitor compares DUT strobes.
module tb_ble_rx_dewhiten_crc;
  localparam int MAXL = 37;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [5:0]  ch_idx = '0;
  logic [23:0] crc_init = '0;
  logic        bit_in = 1'b0, bit_valid = 1'b0;
  logic [7:0]  rx_byte, pdu_len;
  logic        rx_byte_valid, busy, done, crc_ok, len_err;

  ble_rx_dewhiten_crc #(.CH_IDX_W(6), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ch_idx(ch_idx),
    .crc_init(crc_init), .bit_in(bit_in), .bit_valid(bit_valid), .rx_byte(rx_byte),
    .rx_byte_valid(rx_byte_valid), .pdu_len(pdu_len), .busy(busy), .done(done),
    .crc_ok(crc_ok), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    logic [7:0] val;
    bit         ok;
    bit         lerr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0, n_err = 0;
  bit   plain[$];
  bit   wseq[$];
  bit   last_has_done, last_ok, last_lerr;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) if (rst_n) begin
    if (rx_byte_valid) begin
      if (exp_q.size() == 0 || exp_q[0].is_done) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_byte: got 0x%0h expected no strobe", rx_byte);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rx_byte", rx_byte, mon_e.val);
      end
    end
    if (done) begin
      if (exp_q.size() == 0 || !exp_q[0].is_done) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        mon_e = exp_q.pop_front();
        chk("crc_ok_at_done", crc_ok, mon_e.ok);
        chk("len_err_at_done", len_err, mon_e.lerr);
        chk("pdu_len_at_done", pdu_len, mon_e.val);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  // Whitening sequence: state polynomial repeatedly multiplied by x modulo x^7+x^4+1
  function automatic void gen_white(input logic [5:0] ch, input int n);
    int s;
    s = 1;
    for (int i = 1; i <= 6; i++) s = s | (int'(ch[6-i]) << i);
    wseq.delete();
    for (int k = 0; k < n; k++) begin
      wseq.push_back(s[6]);
      s = s << 1;
      if (s[7]) s = s ^ 'h91;
    end
  endfunction

  // CRC as remainder of (init*x^n + M(x)*x^24) mod G, by long division on a bit string
  function automatic logic [23:0] crc_model(input logic [23:0] init, input int n);
    bit a[$];
    logic [24:0] g;
    logic [23:0] r;
    g = 25'h100065B;
    for (int i = 0; i < n; i++) a.push_back(plain[i]);
    for (int i = 0; i < 24; i++) a.push_back(1'b0);
    for (int i = 0; i < 24; i++) a[i] = a[i] ^ init[23-i];
    for (int i = 0; i + 24 < a.size(); i++)
      if (a[i]) for (int j = 0; j < 25; j++) a[i+j] = a[i+j] ^ g[24-j];
    for (int i = 0; i < 24; i++) r[23-i] = a[a.size()-24+i];
    return r;
  endfunction

  function automatic logic [7:0] byte_at(input int k);
    logic [7:0] v;
    for (int j = 0; j < 8; j++) v[j] = plain[8*k+j];
    return v;
  endfunction

  task automatic build_pkt(input logic [7:0] h0, input logic [7:0] lenf, input int npay,
                           input logic [23:0] init, input int flip);
    logic [7:0]  b;
    logic [23:0] c;
    plain.delete();
    for (int k = 0; k < 2 + npay; k++) begin
      b = (k == 0) ? h0 : (k == 1) ? lenf : 8'($urandom);
      for (int j = 0; j < 8; j++) plain.push_back(b[j]);
    end
    c = crc_model(init, plain.size());
    for (int i = 23; i >= 0; i--) plain.push_back(c[i]);
    if (flip >= 0) plain[16 + 8*npay + flip] = ~plain[16 + 8*npay + flip];
  endtask

  // Expected DUT behaviour when the first n plain bits of the packet are delivered
  task automatic expect_pkt(input logic [23:0] init, input int n);
    logic [7:0]  lenv;
    logic [23:0] rx;
    int nb, m;
    exp_t e;
    lenv = byte_at(1);
    nb   = (lenv > MAXL) ? 16 : 16 + 8*int'(lenv);
    m    = (n < nb) ? n : nb;
    last_has_done = 1'b0;
    for (int k = 0; k < m/8; k++) begin
      e = '{is_done: 1'b0, val: byte_at(k), ok: 1'b0, lerr: 1'b0};
      exp_q.push_back(e);
    end
    if (lenv > MAXL && n >= 16) begin
      e = '{is_done: 1'b1, val: lenv, ok: 1'b0, lerr: 1'b1};
      exp_q.push_back(e);
      last_has_done = 1'b1; last_ok = 1'b0; last_lerr = 1'b1;
    end else if (lenv <= MAXL && n >= nb + 24) begin
      for (int i = 0; i < 24; i++) rx[23-i] = plain[nb+i];
      e = '{is_done: 1'b1, val: lenv, ok: (rx == crc_model(init, nb)), lerr: 1'b0};
      exp_q.push_back(e);
      last_has_done = 1'b1; last_ok = e.ok; last_lerr = 1'b0;
    end
  endtask

  // Entered and left at posedge+1
  task automatic drive(input logic [5:0] ch, input logic [23:0] init, input int n, input bit do_abort);
    gen_white(ch, n);
    expect_pkt(init, n);
    start = 1'b1; ch_idx = ch; crc_init = init; bit_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        bit_valid = 1'b0; bit_in = 1'($urandom);
        @(posedge clk); #1;
      end
      bit_valid = 1'b1; bit_in = plain[i] ^ wseq[i];
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    if (do_abort) begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end
  endtask

  task automatic finish_pkt(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    chk({nm, "_idle"}, busy, 0);
    if (last_has_done) begin
      chk({nm, "_crc_ok_held"}, crc_ok, last_ok);
      chk({nm, "_len_err_held"}, len_err, last_lerr);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rx_byte"}, rx_byte, 0);
    chk({nm, "_rx_byte_valid"}, rx_byte_valid, 0);
    chk({nm, "_pdu_len"}, pdu_len, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_crc_ok"}, crc_ok, 0);
    chk({nm, "_len_err"}, len_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lenf;
    int npay, flip;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_all_zero("post_reset");

    // bits while idle are ignored
    repeat (5) begin
      bit_valid = 1'b1; bit_in = 1'($urandom);
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    last_has_done = 1'b0;
    finish_pkt("idle_bits");

    // all-zero input exposes the raw whitening sequence on channel 0
    gen_white(6'd0, 16);
    plain = wseq;
    drive(6'd0, 24'h555555, 16, 1'b0);
    finish_pkt("white_seq");

    build_pkt(8'h02, 8'h06, 6, 24'h555555, -1);
    drive(6'd37, 24'h555555, plain.size(), 1'b0);
    finish_pkt("pkt_ch37");

    build_pkt(8'h02, 8'h06, 6, 24'h555555, 11);
    drive(6'd37, 24'h555555, plain.size(), 1'b0);
    finish_pkt("pkt_crc_flip");

    build_pkt(8'h02, 8'h40, 4, 24'h123456, -1);
    drive(6'd21, 24'h123456, plain.size(), 1'b0);
    finish_pkt("len_err");

    build_pkt(8'h00, 8'h00, 0, 24'hABCDEF, -1);
    drive(6'd3, 24'hABCDEF, plain.size(), 1'b0);
    finish_pkt("zero_len");

    build_pkt(8'h01, 8'h06, 6, 24'h555555, -1);
    drive(6'd5, 24'h555555, 16 + 8*2 + 3, 1'b1);
    build_pkt(8'h02, 8'h03, 3, 24'h0F0F0F, -1);
    drive(6'd12, 24'h0F0F0F, plain.size(), 1'b0);
    finish_pkt("abort_restart");

    build_pkt(8'h02, 8'h04, 4, 24'h777777, -1);
    drive(6'($urandom_range(0, 39)), 24'h777777, 16 + 32 + 10, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_crc_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    last_has_done = 1'b0;
    finish_pkt("mid_crc_reset");
    build_pkt(8'h02, 8'h05, 5, 24'h555555, -1);
    drive(6'd9, 24'h555555, plain.size(), 1'b0);
    finish_pkt("after_reset");

    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        lenf = 8'($urandom_range(MAXL + 1, 255));
        npay = 2;
        flip = -1;
      end else begin
        lenf = 8'($urandom_range(0, MAXL));
        npay = int'(lenf);
        flip = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 23)) : -1;
      end
      crc_init = 24'($urandom);
      build_pkt(8'($urandom), lenf, npay, crc_init, flip);
      drive(6'($urandom_range(0, 39)), crc_init, plain.size(), 1'b0);
      finish_pkt("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
